// File: rtl/sample_pair_packer_pkg.sv
// Shared types and widths for the sample pair packer.
// Optional read-ahead is selected with PACKER_PREFETCH_EN.
package packer_pkg;

    localparam int DWIDTH  = 16;
    localparam int DDWIDTH = 2 * DWIDTH;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_WAIT_LO
    } fetch_st_e;

    typedef enum logic {
        S_IDLE,
        S_ACK
    } serve_st_e;

endpackage

// File: rtl/sample_pair_packer_if.sv
// Source-side and filter-side four-phase handshakes of the packer.
// master = packer, slave = sample source plus filter.
interface sample_pair_packer_if;
    import packer_pkg::*;

    logic               sample_req;
    logic               sample_ack;
    logic [0:DWIDTH-1]  sample_data;
    logic               pair_req;
    logic               pair_ack;
    logic [0:DDWIDTH-1] pair_data;

    modport master (
        output sample_req,
        input  sample_ack,
        input  sample_data,
        input  pair_req,
        output pair_ack,
        output pair_data
    );

    modport slave (
        input  sample_req,
        output sample_ack,
        output sample_data,
        output pair_req,
        input  pair_ack,
        input  pair_data
    );

endinterface

// File: rtl/sample_pair_packer_fetch.sv
// hs_fetch: four-phase initiator fetching one sample per transaction.
// done_o pulses for one cycle once data_o holds the new sample.
module hs_fetch
    import packer_pkg::*;
#(
    parameter int W = DWIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         ack_i,
    input  logic [0:W-1] data_i,
    output logic         req_o,
    output logic         done_o,
    output logic [0:W-1] data_o
);

    fetch_st_e    st_q, st_d;
    logic         req_q, req_d;
    logic         done_q, done_d;
    logic [0:W-1] data_q, data_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q   <= F_IDLE;
            req_q  <= 1'b0;
            done_q <= 1'b0;
            data_q <= '0;
        end else begin
            st_q   <= st_d;
            req_q  <= req_d;
            done_q <= done_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        req_d  = req_q;
        done_d = 1'b0;
        data_d = data_q;
        unique case (st_q)
            F_IDLE: begin
                if (en_i) begin
                    st_d  = F_REQ;
                    req_d = 1'b1;
                end
            end
            F_REQ: begin
                if (ack_i) begin
                    st_d   = F_WAIT_LO;
                    req_d  = 1'b0;
                    done_d = 1'b1;
                    data_d = data_i;
                end
            end
            F_WAIT_LO: begin
                if (!ack_i) st_d = F_IDLE;
            end
            default: begin
                st_d  = F_IDLE;
                req_d = 1'b0;
            end
        endcase
    end

    assign req_o  = req_q;
    assign done_o = done_q;
    assign data_o = data_q;

endmodule

// File: rtl/sample_pair_packer.sv
// Packs two consecutive samples into one pair word for the filter input.
// Define PACKER_PREFETCH_EN to assemble the next pair while one is held.
module sample_pair_packer
    import packer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    sample_pair_packer_if.master bus
);

    logic               fetch_en;
    logic               cap_done;
    logic [0:DWIDTH-1]  cap_data;

    logic               slot_q, slot_d;
    logic               full_q, full_d;
    logic               wv_q, wv_d;
    logic [0:DWIDTH-1]  a0_q, a0_d;
    logic [0:DWIDTH-1]  a1_q, a1_d;
    logic [0:DDWIDTH-1] out_q, out_d;
    serve_st_e          srv_q, srv_d;

    logic               rel;
    logic               comp;
    logic               wv_kept;
    logic               have_pair;
    logic               move;
    logic [0:DDWIDTH-1] asm_word;

`ifdef PACKER_PREFETCH_EN
    assign fetch_en = !full_q;
`else
    assign fetch_en = bus.pair_req && !wv_q;
`endif

    hs_fetch #(
        .W(DWIDTH)
    ) u_fetch (
        .clk   (clk),
        .rst   (rst),
        .en_i  (fetch_en),
        .ack_i (bus.sample_ack),
        .data_i(bus.sample_data),
        .req_o (bus.sample_req),
        .done_o(cap_done),
        .data_o(cap_data)
    );

    // Release frees the output register before a waiting pair moves in.
    always_comb begin
        rel       = (srv_q == S_ACK) && !bus.pair_req;
        comp      = cap_done && slot_q;
        wv_kept   = wv_q && !rel;
        have_pair = full_q || comp;
        move      = have_pair && !wv_kept;
        asm_word  = full_q ? {a0_q, a1_q} : {a0_q, cap_data};
        slot_d    = cap_done ? ~slot_q : slot_q;
        a0_d      = (cap_done && !slot_q) ? cap_data : a0_q;
        a1_d      = comp ? cap_data : a1_q;
        full_d    = have_pair && !move;
        wv_d      = move || wv_kept;
        out_d     = move ? asm_word : out_q;
    end

    always_comb begin
        srv_d = srv_q;
        unique case (srv_q)
            S_IDLE: if (bus.pair_req && wv_q) srv_d = S_ACK;
            S_ACK:  if (!bus.pair_req) srv_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_q <= 1'b0;
            full_q <= 1'b0;
            wv_q   <= 1'b0;
            a0_q   <= '0;
            a1_q   <= '0;
            out_q  <= '0;
            srv_q  <= S_IDLE;
        end else begin
            slot_q <= slot_d;
            full_q <= full_d;
            wv_q   <= wv_d;
            a0_q   <= a0_d;
            a1_q   <= a1_d;
            out_q  <= out_d;
            srv_q  <= srv_d;
        end
    end

    assign bus.pair_ack  = (srv_q == S_ACK);
    assign bus.pair_data = out_q;

endmodule
